trap_ctrl: RTL and testbench

- Pipeline redirect and trap sequencer for the 5-stage RV32I core.
- Arbitrates PC redirects from the EX-stage branch unit, synchronous exceptions, MRET and machine interrupts. Drives br_taken/br_target/hold_flag_if into the fetch stage and flushes ID/EX.
- Performs the multi-cycle CSR update sequence (mepc, mcause, mstatus) on trap entry and return.

---
 rtl/trap_ctrl_pkg.sv | 50 +++++
 rtl/trap_ctrl_irq_sync.sv | 25 ++
 rtl/trap_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, mcause codes,
// mstatus/mie bit positions, FSM state encoding and mstatus update helpers.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_M_TIMER = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_M_EXT   = 32'h8000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_W_MEPC       = 3'd1,
    ST_W_MCAUSE     = 3'd2,
    ST_W_MSTATUS    = 3'd3,
    ST_REDIRECT     = 3'd4,
    ST_MRET_W       = 3'd5,
    ST_RET_REDIRECT = 3'd6
  } state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
  function automatic logic [31:0] mstatus_trap_entry(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchroniser bringing the asynchronous external interrupt
// level into the clk domain. STAGES must be at least 2.
module trap_ctrl_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Pipeline redirect and trap sequencer for the 5-stage RV32I core.
// Arbitrates branch redirects, exceptions, MRET and machine interrupts and
// sequences the mepc/mcause/mstatus writes on trap entry and return.
// Optional build macro: TRAP_VECTORED_EN (vectored interrupt targets when
// mtvec mode is 2'b01).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          IRQ_SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MSTATUS   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken_in,
  input  logic [31:0] br_target_in,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        hold_flag_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [29:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;

  logic        irq_ext_sync_s;
  logic        irq_ext_pend_s;
  logic        irq_tmr_pend_s;
  logic        irq_take_s;
  logic [31:0] trap_base_s;
  logic [31:0] trap_target_s;
  logic        unused_s;

  trap_ctrl_irq_sync #(
    .STAGES (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (irq_ext),
    .sync_o  (irq_ext_sync_s)
  );

  assign irq_ext_pend_s = irq_ext_sync_s & csr_mie[MIE_MEIE];
  assign irq_tmr_pend_s = irq_timer & csr_mie[MIE_MTIE];
  assign irq_take_s     = (irq_ext_pend_s | irq_tmr_pend_s)
                          & csr_mstatus[MSTATUS_MIE] & commit_valid;

  assign trap_base_s = {csr_mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Only interrupts (cause MSB set) are vectored; exceptions use the base.
  assign trap_target_s = ((csr_mtvec[1:0] == 2'b01) && cause_q[31])
                         ? trap_base_s + {25'd0, cause_q[4:0], 2'b00}
                         : trap_base_s;
  assign unused_s = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:0], RESET_MSTATUS};
`else
  assign trap_target_s = trap_base_s;
  assign unused_s = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:0],
                      csr_mtvec[1:0], RESET_MSTATUS};
`endif

  assign busy = (state_q != ST_IDLE);

  // State and latched trap context; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Event arbitration, next-state and per-state outputs; all outputs held
  // low while reset is asserted.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    csr_we       = 1'b0;
    csr_waddr    = 12'h000;
    csr_wdata    = 32'h0000_0000;
    br_taken     = 1'b0;
    br_target    = 32'h0000_0000;
    hold_flag_if = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    if (!rst_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exc_valid) begin
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            hold_flag_if = 1'b1;
            epc_d        = exc_pc[31:2];
            cause_d      = exc_cause;
            state_d      = ST_W_MEPC;
          end else if (mret_valid) begin
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            hold_flag_if = 1'b1;
            state_d      = ST_MRET_W;
          end else if (irq_take_s) begin
            // The commit-point instruction is not executed; it becomes mepc.
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            hold_flag_if = 1'b1;
            epc_d        = commit_pc[31:2];
            cause_d      = irq_ext_pend_s ? MCAUSE_M_EXT : MCAUSE_M_TIMER;
            state_d      = ST_W_MEPC;
          end else begin
            br_taken  = br_taken_in;
            br_target = br_target_in;
            flush_id  = br_taken_in;
            flush_ex  = br_taken_in;
          end
        end
        ST_W_MEPC: begin
          csr_we       = 1'b1;
          csr_waddr    = CSR_MEPC;
          csr_wdata    = {epc_q, 2'b00};
          hold_flag_if = 1'b1;
          state_d      = ST_W_MCAUSE;
        end
        ST_W_MCAUSE: begin
          csr_we       = 1'b1;
          csr_waddr    = CSR_MCAUSE;
          csr_wdata    = cause_q;
          hold_flag_if = 1'b1;
          state_d      = ST_W_MSTATUS;
        end
        ST_W_MSTATUS: begin
          csr_we       = 1'b1;
          csr_waddr    = CSR_MSTATUS;
          csr_wdata    = mstatus_trap_entry(csr_mstatus);
          hold_flag_if = 1'b1;
          state_d      = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          br_taken  = 1'b1;
          br_target = trap_target_s;
          flush_id  = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_MRET_W: begin
          csr_we       = 1'b1;
          csr_waddr    = CSR_MSTATUS;
          csr_wdata    = mstatus_mret(csr_mstatus);
          hold_flag_if = 1'b1;
          state_d      = ST_RET_REDIRECT;
        end
        ST_RET_REDIRECT: begin
          br_taken  = 1'b1;
          br_target = {csr_mepc[31:2], 2'b00};
          state_d   = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes the expected output
// beats; a negedge monitor pops and compares whenever the DUT drives
// csr_we, br_taken, hold_flag_if or a flush.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken_in;
  logic [31:0] br_target_in;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        irq_ext;
  logic        irq_timer;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        hold_flag_if;
  logic        flush_id;
  logic        flush_ex;
  logic        busy;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        br;
    logic [31:0] tgt;
    logic        hold;
    logic        fid;
    logic        fex;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  trap_ctrl #(.IRQ_SYNC_STAGES(2), .RESET_MSTATUS(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_taken_in(br_taken_in), .br_target_in(br_target_in),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .irq_ext(irq_ext), .irq_timer(irq_timer),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .br_taken(br_taken), .br_target(br_target), .hold_flag_if(hold_flag_if),
    .flush_id(flush_id), .flush_ex(flush_ex), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_trap_entry();
    exp_q.push_back('{we:1'b0, addr:12'h000, data:32'h0, br:1'b0, tgt:32'h0,
                      hold:1'b1, fid:1'b1, fex:1'b1});
  endtask

  task automatic push_csr(input logic [11:0] a, input logic [31:0] d);
    exp_q.push_back('{we:1'b1, addr:a, data:d, br:1'b0, tgt:32'h0,
                      hold:1'b1, fid:1'b0, fex:1'b0});
  endtask

  task automatic push_redir(input logic [31:0] t, input logic fi, input logic fe);
    exp_q.push_back('{we:1'b0, addr:12'h000, data:32'h0, br:1'b1, tgt:t,
                      hold:1'b0, fid:fi, fex:fe});
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    if (rst_n && (csr_we || br_taken || hold_flag_if || flush_id || flush_ex)) begin
      got = '{we:csr_we, addr:csr_waddr, data:csr_wdata, br:br_taken,
              tgt:br_target, hold:hold_flag_if, fid:flush_id, fex:flush_ex};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got we=%0b addr=%h data=%h br=%0b tgt=%h hold=%0b fid=%0b fex=%0b, expected none",
                 got.we, got.addr, got.data, got.br, got.tgt, got.hold, got.fid, got.fex);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got we=%0b addr=%h data=%h br=%0b tgt=%h hold=%0b fid=%0b fex=%0b, expected we=%0b addr=%h data=%h br=%0b tgt=%h hold=%0b fid=%0b fex=%0b",
                   got.we, got.addr, got.data, got.br, got.tgt, got.hold, got.fid, got.fex,
                   e.we, e.addr, e.data, e.br, e.tgt, e.hold, e.fid, e.fex);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    br_taken_in = 1'b1; br_target_in = 32'h0000_0DEC;
    exc_valid = 1'b0; exc_cause = 32'h0; exc_pc = 32'h0;
    mret_valid = 1'b0; commit_valid = 1'b0; commit_pc = 32'h0;
    irq_ext = 1'b0; irq_timer = 1'b0;
    csr_mstatus = 32'h0; csr_mie = 32'h0; csr_mtvec = 32'h0000_0200; csr_mepc = 32'h0;

    // Reset: outputs low even with a branch request present.
    repeat (3) cyc();
    check("reset_br_taken", {63'd0, br_taken}, 64'd0);
    check("reset_flush", {62'd0, flush_id, flush_ex}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    br_taken_in = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Plain branch redirect in IDLE.
    br_taken_in = 1'b1; br_target_in = 32'h0000_0100;
    push_redir(32'h0000_0100, 1'b1, 1'b1);
    cyc();
    br_taken_in = 1'b0;
    check("branch_busy", {63'd0, busy}, 64'd0);
    cyc();

    // Exception: cause 2 at pc 0x80, mtvec 0x200.
    csr_mstatus = 32'h0000_0008;
    exc_valid = 1'b1; exc_cause = 32'h2; exc_pc = 32'h0000_0080;
    push_trap_entry();
    push_csr(12'h341, 32'h0000_0080);
    push_csr(12'h342, 32'h0000_0002);
    push_csr(12'h300, 32'h0000_1880);
    push_redir(32'h0000_0200, 1'b1, 1'b0);
    cyc();
    exc_valid = 1'b0;
    check("exc_busy_t1", {63'd0, busy}, 64'd1);
    repeat (6) cyc();

    // Timer interrupt with MIE=1.
    csr_mie = 32'h0000_0080;
    irq_timer = 1'b1; commit_valid = 1'b1; commit_pc = 32'h0000_0044;
    push_trap_entry();
    push_csr(12'h341, 32'h0000_0044);
    push_csr(12'h342, 32'h8000_0007);
    push_csr(12'h300, 32'h0000_1880);
    push_redir(32'h0000_0200, 1'b1, 1'b0);
    cyc();
    irq_timer = 1'b0; commit_valid = 1'b0;
    repeat (6) cyc();

    // Same stimulus with MIE=0: no trap, no beats.
    csr_mstatus = 32'h0;
    irq_timer = 1'b1; commit_valid = 1'b1;
    repeat (2) cyc();
    check("mie0_busy", {63'd0, busy}, 64'd0);
    irq_timer = 1'b0; commit_valid = 1'b0;
    cyc();

    // Exception and branch together; misaligned pc, mtvec mode bits set.
    csr_mtvec = 32'h0000_0201;
    exc_valid = 1'b1; exc_cause = 32'h5; exc_pc = 32'h0000_0083;
    br_taken_in = 1'b1; br_target_in = 32'h0000_0300;
    push_trap_entry();
    push_csr(12'h341, 32'h0000_0080);
    push_csr(12'h342, 32'h0000_0005);
    push_csr(12'h300, 32'h0000_1800);
    push_redir(32'h0000_0200, 1'b1, 1'b0);
    cyc();
    exc_valid = 1'b0; br_taken_in = 1'b0;
    repeat (6) cyc();

    // MRET with MPIE=1, mepc 0x48.
    csr_mstatus = 32'h0000_1880; csr_mepc = 32'h0000_0048;
    mret_valid = 1'b1;
    push_trap_entry();
    push_csr(12'h300, 32'h0000_1888);
    push_redir(32'h0000_0048, 1'b0, 1'b0);
    cyc();
    mret_valid = 1'b0;
    repeat (4) cyc();

    // External interrupt beats timer; vectored target when enabled.
    csr_mstatus = 32'h0000_0008; csr_mie = 32'h0000_0880; csr_mtvec = 32'h0000_0201;
    irq_ext = 1'b1; irq_timer = 1'b1;
    repeat (3) cyc();
    commit_valid = 1'b1; commit_pc = 32'h0000_0060;
    push_trap_entry();
    push_csr(12'h341, 32'h0000_0060);
    push_csr(12'h342, 32'h8000_000B);
    push_csr(12'h300, 32'h0000_1880);
`ifdef TRAP_VECTORED_EN
    push_redir(32'h0000_022C, 1'b1, 1'b0);
`else
    push_redir(32'h0000_0200, 1'b1, 1'b0);
`endif
    cyc();
    irq_ext = 1'b0; irq_timer = 1'b0; commit_valid = 1'b0;
    repeat (6) cyc();

    // Reset at T2 of a trap: only T0 and the mepc write are seen.
    csr_mtvec = 32'h0000_0200;
    exc_valid = 1'b1; exc_cause = 32'h4; exc_pc = 32'h0000_0090;
    push_trap_entry();
    push_csr(12'h341, 32'h0000_0090);
    cyc();
    exc_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("reset_mid_busy", {63'd0, busy}, 64'd0);
    repeat (6) cyc();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
